uart_tx_cfg: RTL and testbench

Configurable UART transmitter for the host serial link, and the next generation of the fixed 8N1 transmitter. Adds compile-time data width, run-time baud divisor, optional even/odd parity and one or two stop bits. A one-entry holding register allows the next word to be accepted during the current frame, so frames go out back-to-back with no idle gap. It sits between the on-chip byte producer (ready/valid) and the TX pin.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_bit_timer.sv | 44 ++++
 rtl/uart_tx_cfg.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART transmitter and
// its future receiver counterpart.
//   state_e        - frame state machine encoding
//   PAR_*          - encodings of the 2-bit run-time parity mode
//   parity_bit()   - parity over up to MAX_DATA_WIDTH data bits
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   // Mode 3 is reserved and behaves as no parity.
   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   // Widest data word either direction of the link supports.
   localparam int unsigned MAX_DATA_WIDTH = 9;

   // Callers zero-extend narrower words; the extra zeros do not change the XOR.
   // odd = 0 gives the even-parity bit, odd = 1 its inverse.
   function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clocks inside one serial bit.
//   i_clk, i_rst   - clock, synchronous active-high reset
//   i_div          - clocks per bit (0 behaves as 1)
//   i_en           - count while high; counter held at 0 while low
//   i_restart      - force the counter back to 0 (start of a new frame)
//   o_bit_done     - high for the last clock of the current bit
// The counter runs 0 .. div-1; o_bit_done is asserted while it sits at div-1
// and the counter wraps to 0 on that edge.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [DIV_WIDTH-1:0] i_div,
   input  logic                 i_en,
   input  logic                 i_restart,
   output logic                 o_bit_done
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;
   logic [DIV_WIDTH-1:0] last_cnt;

   always_comb begin
      // Divisor 0 shares the terminal count of divisor 1.
      last_cnt   = (i_div == '0) ? '0 : (i_div - DIV_WIDTH'(1));
      o_bit_done = i_en && (cnt_q == last_cnt);
      cnt_d      = cnt_q + DIV_WIDTH'(1);
      if (!i_en || i_restart || o_bit_done) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a one-word holding register.
//   DATA_WIDTH      - data bits per frame (5..9)
//   DIV_WIDTH       - width of the clocks-per-bit divisor
//   i_clk, i_rst    - clock, synchronous active-high reset
//   i_clk_per_bit   - clocks per bit, 0 behaves as 1
//   i_parity_mode   - 0 none, 1 even, 2 odd, 3 none
//   i_two_stop      - 1 = two stop bits
//   i_data          - word to send
//   i_data_valid    - producer offers i_data
//   o_data_rdy      - holding register empty (registered)
//   o_tx            - serial line, idle high (registered)
//   o_busy          - frame in progress (registered)
//
// Handshake: a word moves into the holding register on every rising edge
// where o_data_rdy and i_data_valid are both high. i_data is ignored while
// i_data_valid is low, and i_data_valid may stay high while o_data_rdy is
// low without anything transferring. Once taken, the producer's word is the
// transmitter's responsibility; o_data_rdy drops the following cycle and
// rises again the cycle after the word moves into the shift register.
//
// Configuration inputs are sampled only on the edge that starts a frame, so
// they may change freely while a frame is on the line.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DIV_WIDTH-1:0]  i_clk_per_bit,
   input  logic [1:0]            i_parity_mode,
   input  logic                  i_two_stop,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_data_valid,
   output logic                  o_data_rdy,
   output logic                  o_tx,
   output logic                  o_busy
);

   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   state_e                state_q,     state_d;
   logic [DATA_WIDTH-1:0] hold_q,      hold_d;
   logic                  hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0] shift_q,     shift_d;
   logic [IDX_W-1:0]      idx_q,       idx_d;
   logic                  stop_cnt_q,  stop_cnt_d;
   logic [DIV_WIDTH-1:0]  div_q,       div_d;
   logic [1:0]            par_mode_q,  par_mode_d;
   logic                  two_stop_q,  two_stop_d;
   logic                  tx_q,        tx_d;
   logic                  busy_q,      busy_d;

   logic bit_done;
   logic accept;
   logic frame_end;
   logic start_frame;
   logic par_en;
   logic par_val;

   uart_bit_timer #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_bit_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_div      (div_q),
      .i_en       (state_q != ST_IDLE),
      .i_restart  (start_frame),
      .o_bit_done (bit_done)
   );

   always_comb begin
      accept    = !hold_full_q && i_data_valid;
      par_en    = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
      par_val   = parity_bit(MAX_DATA_WIDTH'(shift_q), par_mode_q == PAR_ODD);
      // Last clock of the last stop bit.
      frame_end = (state_q == ST_STOP) && bit_done && (!two_stop_q || stop_cnt_q);
      // A held word launches from IDLE or straight off the final stop clock,
      // which is what keeps consecutive frames gap-free.
      start_frame = hold_full_q && ((state_q == ST_IDLE) || frame_end);

      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      stop_cnt_d  = stop_cnt_q;
      div_d       = div_q;
      par_mode_d  = par_mode_q;
      two_stop_d  = two_stop_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_START: begin
            if (bit_done) begin
               state_d = ST_DATA;
               idx_d   = '0;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d    = par_en ? ST_PARITY : ST_STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               state_d    = ST_STOP;
               stop_cnt_d = 1'b0;
            end
         end
         ST_STOP: begin
            if (frame_end) begin
               state_d = ST_IDLE;
            end else if (bit_done) begin
               stop_cnt_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The holding register is full on a launch edge, so o_data_rdy is low
      // and no new word can be accepted on that same edge.
      if (start_frame) begin
         state_d     = ST_START;
         shift_d     = hold_q;
         div_d       = i_clk_per_bit;
         par_mode_d  = i_parity_mode;
         two_stop_d  = i_two_stop;
         idx_d       = '0;
         stop_cnt_d  = 1'b0;
         hold_full_d = 1'b0;
      end else if (accept) begin
         hold_d      = i_data;
         hold_full_d = 1'b1;
      end

      // Line level for the coming cycle, decoded from the next state so the
      // pin itself is a flop.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[idx_d];
         ST_PARITY: tx_d = par_val;
         default:   tx_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         idx_q       <= '0;
         stop_cnt_q  <= 1'b0;
         div_q       <= '0;
         par_mode_q  <= PAR_NONE;
         two_stop_q  <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         stop_cnt_q  <= stop_cnt_d;
         div_q       <= div_d;
         par_mode_q  <= par_mode_d;
         two_stop_q  <= two_stop_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
      end
   end

   assign o_data_rdy = ~hold_full_q;
   assign o_tx       = tx_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg (8-bit instance plus a
// 5-bit instance for the single-cycle-bit cases).
module tb_uart_tx_cfg;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // 8-bit instance
   logic [15:0] clk_per_bit;
   logic [1:0]  parity_mode;
   logic        two_stop;
   logic [7:0]  data;
   logic        data_valid;
   logic        data_rdy;
   logic        tx;
   logic        busy;

   // 5-bit instance
   logic [15:0] d5_clk_per_bit;
   logic [4:0]  d5_data;
   logic        d5_data_valid;
   logic        d5_data_rdy;
   logic        d5_tx;
   logic        d5_busy;

   uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16)) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_clk_per_bit (clk_per_bit),
      .i_parity_mode (parity_mode),
      .i_two_stop    (two_stop),
      .i_data        (data),
      .i_data_valid  (data_valid),
      .o_data_rdy    (data_rdy),
      .o_tx          (tx),
      .o_busy        (busy)
   );

   uart_tx_cfg #(.DATA_WIDTH(5), .DIV_WIDTH(16)) u_dut5 (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_clk_per_bit (d5_clk_per_bit),
      .i_parity_mode (2'd0),
      .i_two_stop    (1'b0),
      .i_data        (d5_data),
      .i_data_valid  (d5_data_valid),
      .o_data_rdy    (d5_data_rdy),
      .o_tx          (d5_tx),
      .o_busy        (d5_busy)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [0:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   // seq holds the expected line bits LSB first: start, data, [parity], stop(s).
   typedef struct {
      logic [7:0]  data;
      logic [15:0] div;
      logic [1:0]  par;
      logic        two;
      logic [11:0] seq;
      int          nbits;
      int          chg_cyc;   // cycle inside the frame to alter i_clk_per_bit, -1 = never
      logic [15:0] chg_div;
   } vec_t;

   localparam int NVEC = 9;
   vec_t vecs[NVEC];

   // ---------------- driver tasks ----------------
   task automatic run_frame(input int vi);
      vec_t       v;
      int         eff_div;
      int         cyc;
      int         mism;
      logic [0:0] e;
      v       = vecs[vi];
      eff_div = (v.div == 16'd0) ? 1 : int'(v.div);
      @(negedge clk);
      check($sformatf("v%0d rdy_idle", vi), data_rdy, 1);
      clk_per_bit = v.div;
      parity_mode = v.par;
      two_stop    = v.two;
      data        = v.data;
      data_valid  = 1'b1;
      @(posedge clk);                 // handshake edge E
      @(negedge clk);
      data_valid = 1'b0;
      data       = 8'($urandom);
      check($sformatf("v%0d rdy_after_accept", vi), data_rdy, 0);
      check($sformatf("v%0d tx_before_start", vi), tx, 1);
      exp_q.delete();
      for (int b = 0; b < v.nbits; b++)
         for (int c = 0; c < eff_div; c++)
            exp_q.push_back(v.seq[b]);
      cyc = 0;
      for (int b = 0; b < v.nbits; b++) begin
         mism = 0;
         for (int c = 0; c < eff_div; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (tx !== e[0] || busy !== 1'b1) mism++;
            if (cyc == 0 && data_rdy !== 1'b1) mism++;
            if (cyc == v.chg_cyc) clk_per_bit = v.chg_div;
            cyc++;
         end
         check($sformatf("v%0d bit%0d bad_cycles", vi, b), mism, 0);
      end
      @(negedge clk);
      check($sformatf("v%0d busy_after", vi), busy, 0);
      check($sformatf("v%0d tx_after", vi), tx, 1);
   endtask

   task automatic run5(input logic [15:0] div);
      logic [6:0] seq;
      seq = {1'b1, 5'h1F, 1'b0};
      @(negedge clk);
      d5_clk_per_bit = div;
      d5_data        = 5'h1F;
      d5_data_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d5_data_valid = 1'b0;
      check($sformatf("w5 div%0d tx_before_start", div), d5_tx, 1);
      for (int b = 0; b < 7; b++) begin
         @(negedge clk);
         check($sformatf("w5 div%0d bit%0d", div, b), d5_tx, seq[b]);
      end
      @(negedge clk);
      check($sformatf("w5 div%0d busy_after", div), d5_busy, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst            = 1'b1;
      clk_per_bit    = 16'd4;
      parity_mode    = 2'd0;
      two_stop       = 1'b0;
      data           = 8'h00;
      data_valid     = 1'b0;
      d5_clk_per_bit = 16'd1;
      d5_data        = 5'h00;
      d5_data_valid  = 1'b0;

      vecs[0] = '{8'hA5, 16'd4, 2'd0, 1'b0, 12'({1'b1, 8'hA5, 1'b0}), 10, -1, 16'd0};
      vecs[1] = '{8'hA5, 16'd4, 2'd1, 1'b0, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, -1, 16'd0};
      vecs[2] = '{8'hA5, 16'd4, 2'd2, 1'b0, 12'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, -1, 16'd0};
      vecs[3] = '{8'h01, 16'd4, 2'd1, 1'b0, 12'({1'b1, 1'b1, 8'h01, 1'b0}), 11, -1, 16'd0};
      vecs[4] = '{8'hA5, 16'd3, 2'd0, 1'b1, 12'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, 5, 16'd7};
      vecs[5] = '{8'h3C, 16'd7, 2'd0, 1'b0, 12'({1'b1, 8'h3C, 1'b0}), 10, -1, 16'd0};
      vecs[6] = '{8'hF0, 16'd2, 2'd3, 1'b0, 12'({1'b1, 8'hF0, 1'b0}), 10, -1, 16'd0};
      vecs[7] = '{8'h80, 16'd2, 2'd2, 1'b1, 12'({1'b1, 1'b1, 1'b0, 8'h80, 1'b0}), 12, -1, 16'd0};
      vecs[8] = '{8'h5A, 16'd1, 2'd2, 1'b0, 12'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, -1, 16'd0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("idle%0d tx", i), tx, 1);
         check($sformatf("idle%0d rdy", i), data_rdy, 1);
         check($sformatf("idle%0d busy", i), busy, 0);
      end

      // Table-driven single frames
      for (int vi = 0; vi < NVEC; vi++) run_frame(vi);

      // Back-to-back: 20 alternating 0x55 / 0xAA frames at divisor 2
      begin
         logic [7:0] words[20];
         for (int i = 0; i < 20; i++) words[i] = (i % 2 == 0) ? 8'h55 : 8'hAA;
         exp_q.delete();
         for (int i = 0; i < 20; i++) begin
            repeat (2) exp_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) repeat (2) exp_q.push_back(words[i][b]);
            repeat (2) exp_q.push_back(1'b1);
         end
         fork
            begin : b2b_driver
               int   idx;
               int   guard;
               logic fire;
               idx   = 0;
               guard = 0;
               @(negedge clk);
               clk_per_bit = 16'd2;
               parity_mode = 2'd0;
               two_stop    = 1'b0;
               data        = words[0];
               data_valid  = 1'b1;
               while (idx < 20 && guard < 2000) begin
                  fire = data_rdy && data_valid;
                  @(negedge clk);
                  guard++;
                  if (fire) begin
                     idx++;
                     if (idx < 20) data = words[idx];
                     else data_valid = 1'b0;
                  end
               end
               data_valid = 1'b0;
            end
            begin : b2b_monitor
               logic       found;
               int         mism;
               logic [0:0] e;
               found = 1'b0;
               for (int i = 0; i < 50 && !found; i++) begin
                  @(negedge clk);
                  if (tx === 1'b0) found = 1'b1;
               end
               check("b2b start_seen", found, 1);
               if (found) begin
                  for (int f = 0; f < 20; f++) begin
                     mism = 0;
                     for (int c = 0; c < 20; c++) begin
                        if (!(f == 0 && c == 0)) @(negedge clk);
                        e = exp_q.pop_front();
                        if (tx !== e[0] || busy !== 1'b1) mism++;
                     end
                     check($sformatf("b2b frame%0d bad_cycles", f), mism, 0);
                  end
                  @(negedge clk);
                  check("b2b busy_after", busy, 0);
               end
            end
         join
      end

      // Reset in the middle of a frame with a second word held
      @(negedge clk);
      clk_per_bit = 16'd4;
      parity_mode = 2'd0;
      two_stop    = 1'b0;
      data        = 8'h3C;
      data_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data = 8'hC3;
      repeat (8) @(negedge clk);
      check("rst_mid busy_before", busy, 1);
      check("rst_mid rdy_before", data_rdy, 0);
      rst        = 1'b1;
      data_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid tx", tx, 1);
      check("rst_mid rdy", data_rdy, 1);
      check("rst_mid busy", busy, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("rst_mid idle%0d tx", i), tx, 1);
         check($sformatf("rst_mid idle%0d busy", i), busy, 0);
      end

      // 5-bit word, divisor 0 and 1: one cycle per bit, 7-cycle frame
      run5(16'd0);
      run5(16'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
